// File: rtl/ai_lane_allocator_pkg.sv
// Shared game definitions: lane geometry, car record field indices and the
// allocator state encoding.
package ai_lane_allocator_pkg;

  localparam int NUM_LANES = 4;

  // Spawn X of each lane, indexed by the 2-bit lane number.
  localparam logic [NUM_LANES-1:0][10:0] LANE_X = {11'd260, 11'd220, 11'd180, 11'd140};

  // Field indices of a car_state_t record.
  localparam int CS_IMG_ID = 0;
  localparam int CS_X      = 1;
  localparam int CS_Y      = 2;
  localparam int CS_WIDTH  = 3;
  localparam int CS_HEIGHT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_PICK  = 2'd2,
    ST_PROBE = 2'd3
  } alloc_state_t;

endpackage

// File: rtl/ai_lane_allocator_lfsr_11.sv
// 11-bit Fibonacci LFSR, x^11 + x^9 + 1, free running. It is maximal length,
// so a non-zero seed never reaches the all-zero state.
module lfsr_11 #(
  parameter logic [10:0] SEED = 11'h5A5
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [10:0] out
);

  logic [10:0] lfsr_q, lfsr_d;

  // Shift left, feeding back the XOR of the x^11 and x^9 taps.
  always_comb lfsr_d = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};

  // State register, reloads the seed on reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/ai_lane_allocator.sv
// Per-frame respawn arbiter: on frame_start, walks the cars in index order
// and gives each requesting car a spawn lane that is neither occupied near
// the top of the screen nor already handed out this frame.
module ai_lane_allocator
  import ai_lane_allocator_pkg::*;
#(
  parameter int          NUM_CARS    = 4,
  parameter logic [10:0] SPAWN_CLEAR = 11'd128,
  parameter logic [10:0] LFSR_SEED   = 11'h5A5
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         frame_start,
  input  logic [NUM_CARS-1:0]          respawn_req,
  input  logic [NUM_CARS-1:0][10:0]    car_y,
  output logic [NUM_CARS-1:0][10:0]    car_x,
  output logic [NUM_CARS-1:0]          respawn_ack,
  output logic                         busy,
  output logic [10:0]                  random
);

  localparam int CW = $clog2(NUM_CARS + 1);  // car_idx must reach NUM_CARS
  localparam int IW = $clog2(NUM_CARS);

  alloc_state_t                 state_q, state_d;
  logic [NUM_CARS-1:0]          pending_q, pending_d;
  logic [NUM_LANES-1:0]         granted_q, granted_d;
  logic [CW-1:0]                car_idx_q, car_idx_d;
  logic [1:0]                   probe_q, probe_d;
  logic [1:0]                   tries_q, tries_d;
  logic [NUM_CARS-1:0][10:0]    car_x_q, car_x_d;
  logic [NUM_CARS-1:0]          ack_q, ack_d;
  logic                         busy_q, busy_d;
  logic                         lane_blocked;
  logic [IW-1:0]                cur;

  lfsr_11 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .out    (random)
  );

  assign cur = car_idx_q[IW-1:0];

  // Probed lane is blocked by a car still near the top or by an earlier grant.
  always_comb begin
    lane_blocked = granted_q[probe_q];
    for (int c = 0; c < NUM_CARS; c++) begin
      if (car_x_q[c] == LANE_X[probe_q] && car_y[c] < SPAWN_CLEAR) lane_blocked = 1'b1;
    end
  end

  // Scan sequencing: latch requests, then per car pick a random start lane
  // and probe up to four lanes, granting the first free one.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    granted_d = granted_q;
    car_idx_d = car_idx_q;
    probe_d   = probe_q;
    tries_d   = tries_q;
    car_x_d   = car_x_q;
    ack_d     = '0;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          pending_d = respawn_req;
          granted_d = '0;
          car_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_LATCH;
        end
      end
      ST_LATCH: state_d = ST_PICK;
      ST_PICK: begin
        if (car_idx_q == CW'(NUM_CARS)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!pending_q[cur]) begin
          car_idx_d = car_idx_q + CW'(1);
        end else begin
          probe_d = random[1:0];
          tries_d = 2'd0;
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (!lane_blocked) begin
          car_x_d[cur]       = LANE_X[probe_q];
          ack_d[cur]         = 1'b1;
          granted_d[probe_q] = 1'b1;
          car_idx_d          = car_idx_q + CW'(1);
          state_d            = ST_PICK;
        end else if (tries_q == 2'd3) begin
          // Every lane blocked: leave the car unserved; its level req
          // brings it back next frame.
          car_idx_d = car_idx_q + CW'(1);
          state_d   = ST_PICK;
        end else begin
          probe_d = probe_q + 2'd1;
          tries_d = tries_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset restores the default lane layout.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      granted_q <= '0;
      car_idx_q <= '0;
      probe_q   <= '0;
      tries_q   <= '0;
      for (int c = 0; c < NUM_CARS; c++) car_x_q[c] <= LANE_X[c % NUM_LANES];
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      granted_q <= granted_d;
      car_idx_q <= car_idx_d;
      probe_q   <= probe_d;
      tries_q   <= tries_d;
      car_x_q   <= car_x_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign car_x       = car_x_q;
  assign respawn_ack = ack_q;
  assign busy        = busy_q;

endmodule
